counter_arb_ctrl: RTL

COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

---
 rtl/counter_arb_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/counter_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_arb_ctrl
// Description : Two-requester round-robin arbiter that owns a shared
//               up/down counter. The winner's direction and step length are
//               latched at grant time. The counter then steps once per RUN
//               cycle for the latched number of steps. A one-cycle done
//               pulse closes the run. Dropping the granted request during
//               RUN aborts the run without a done pulse.
// Ports       : clk         rising-edge clock
//               rst         synchronous active-low reset
//               req[1:0]    per-requester run request
//               dir[1:0]    per-requester direction (1 up, 0 down)
//               len0, len1  per-requester step count
//               gnt[1:0]    one-hot grant (RUN and DONE)
//               done[1:0]   one-cycle completion pulse to the owner
//               busy        state is not IDLE
//               en          count-enable strobe, high in RUN only
//               mod         latched direction of current/last run
//               count       shared counter value
// Revision    : 1.0 - initial release
// ============================================================================
module counter_arb_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             en,
    output logic             mod,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // requester index of the current run
    logic             ptr_q,   ptr_d;     // round-robin priority pointer
    logic             mod_q,   mod_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rem_q,   rem_d;     // steps still to take in RUN
    logic [1:0]       gnt_q,   gnt_d;
    logic [1:0]       done_q,  done_d;
    logic             busy_q,  busy_d;
    logic             en_q,    en_d;

    logic             win;
    logic [CNT_W-1:0] win_len;

    always_comb begin
        // Only a contested request consults the pointer.
        win     = (req == 2'b11) ? ptr_q : req[1];
        win_len = win ? len1 : len0;

        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        mod_d   = mod_q;
        count_d = count_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = win;
                    mod_d   = dir[win];
                    rem_d   = win_len;
                    state_d = (win_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (!req[owner_q]) begin
                    // Abort: counter frozen, no done pulse.
                    state_d = ST_IDLE;
                    ptr_d   = ~owner_q;
                end else begin
                    count_d = mod_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = ~owner_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the next state.
        busy_d = (state_d != ST_IDLE);
        en_d   = (state_d == ST_RUN);
        gnt_d  = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        done_d = (state_d == ST_DONE) ? gnt_d : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            mod_q   <= 1'b0;
            count_q <= '0;
            rem_q   <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            mod_q   <= mod_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign en    = en_q;
    assign mod   = mod_q;
    assign count = count_q;

endmodule
`default_nettype wire
